iobus_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter peripheral on the MCU IOBUS. It drives the board TX pin.
//  The MCU writes bytes to a data port. Bytes are buffered in a FIFO and serialised as 8N1, LSB first.
//  The wrapper's IOBUS_in read mux exposes a status word from this block. The block runs on the MCU clock (sclk).

---
 rtl/iobus_uart_tx_if.sv | 19 +
 rtl/iobus_uart_tx.sv | 189 ++++++++++++++++++
 tb/tb_iobus_uart_tx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/iobus_uart_tx_if.sv
// ---------------------------------------------------------------------------
// iobus_uart_tx_if
// Purpose : MCU IOBUS slice used by the UART transmitter peripheral.
// Signals :
//   iobus_addr  32  bus address from the MCU
//   iobus_out   32  write data from the MCU
//   iobus_wr     1  write strobe, qualified by iobus_addr for one cycle
//   rd_data     32  status word returned to the wrapper's read mux
// Modports: master = MCU side, slave = peripheral side.
// ---------------------------------------------------------------------------
interface iobus_uart_tx_if;
  logic [31:0] iobus_addr;
  logic [31:0] iobus_out;
  logic        iobus_wr;
  logic [31:0] rd_data;

  modport master (output iobus_addr, output iobus_out, output iobus_wr, input rd_data);
  modport slave  (input iobus_addr, input iobus_out, input iobus_wr, output rd_data);
endinterface

// File: rtl/iobus_uart_tx.sv
// ---------------------------------------------------------------------------
// iobus_uart_tx
// Purpose : Memory-mapped 8N1 UART transmitter. Bytes written to DATA_AD are
//           queued in a FIFO and shifted out LSB first on o_tx. A status word
//           is readable at STAT_AD; writing bit0=1 there clears the sticky
//           overflow flag.
// Ports   :
//   i_clk   in   1  MCU clock, all state updates on posedge
//   i_rst   in   1  synchronous active-high reset (aborts any frame in flight)
//   bus     slave   IOBUS address/write data/strobe in, status word out
//   o_tx    out  1  serial line, idle high, registered
// Status  : bit0 BUSY, bit1 EMPTY, bit2 FULL, bit3 OVF, bits[15:8] COUNT.
// FIFO_DEPTH must be a power of two in 2..256 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module iobus_uart_tx #(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115200,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] DATA_AD    = 32'h1110_0000,
  parameter logic [31:0] STAT_AD    = 32'h1110_0004
) (
  input  logic            i_clk,
  input  logic            i_rst,
  iobus_uart_tx_if.slave  bus,
  output logic            o_tx
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [8:0]    DEPTH     = 9'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [8:0]    r_count;
  logic          r_ovf;

  // Serialiser
  state_t        r_state, w_state_next;
  logic [BW-1:0] r_baud, w_baud_next;
  logic [2:0]    r_bit, w_bit_next;
  logic [7:0]    r_shreg, w_shreg_next;
  logic          r_tx, w_tx;
  logic          w_pop;

  logic w_data_wr, w_stat_wr, w_empty, w_full, w_push, w_drop;
  logic [7:0] w_count_disp;
  logic w_unused;

  assign w_data_wr = bus.iobus_wr && (bus.iobus_addr == DATA_AD);
  assign w_stat_wr = bus.iobus_wr && (bus.iobus_addr == STAT_AD);
  assign w_empty   = (r_count == 9'd0);
  assign w_full    = (r_count == DEPTH);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push    = w_data_wr && (!w_full || w_pop);
  assign w_drop    = w_data_wr && w_full && !w_pop;
  assign w_unused  = &{1'b0, bus.iobus_out[31:8]};

  // FSM state register and serialiser datapath
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shreg <= w_shreg_next;
      r_tx    <= w_tx;
    end
  end

  // Next-state logic; the FIFO head is popped straight into the shift register
  // both from IDLE and at the end of STOP so consecutive frames abut.
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shreg_next = r_shreg;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shreg_next = r_mem[r_rd_ptr];
          w_baud_next  = BAUD_LAST;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_baud == '0) begin
          w_baud_next  = BAUD_LAST;
          w_bit_next   = 3'd0;
          w_state_next = S_DATA;
        end else begin
          w_baud_next = r_baud - BW'(1);
        end
      end
      S_DATA: begin
        if (r_baud == '0) begin
          w_baud_next  = BAUD_LAST;
          w_shreg_next = {1'b0, r_shreg[7:1]};
          if (r_bit == 3'd7) begin
            w_state_next = S_STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end else begin
          w_baud_next = r_baud - BW'(1);
        end
      end
      S_STOP: begin
        if (r_baud == '0) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shreg_next = r_mem[r_rd_ptr];
            w_baud_next  = BAUD_LAST;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_baud_next = r_baud - BW'(1);
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Line level follows the current state; registering it costs one cycle of
  // latency but keeps the pin glitch-free.
  always_comb begin
    w_tx = 1'b1;
    case (r_state)
      S_START: w_tx = 1'b0;
      S_DATA:  w_tx = r_shreg[0];
      default: w_tx = 1'b1;
    endcase
  end

  // FIFO storage: no reset so it maps onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.iobus_out[7:0];
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 9'd1;
        2'b01:   r_count <= r_count - 9'd1;
        default: r_count <= r_count;
      endcase
      // Set has priority over a clear in the same cycle.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_stat_wr && bus.iobus_out[0]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // COUNT can reach 256 with the deepest FIFO; the 8-bit field saturates.
  assign w_count_disp = (r_count > 9'd255) ? 8'hFF : r_count[7:0];

  assign bus.rd_data = (bus.iobus_addr == STAT_AD)
                     ? {16'h0000, w_count_disp, 4'h0, r_ovf, w_full, w_empty, (r_state != S_IDLE)}
                     : 32'h0000_0000;

  assign o_tx = r_tx;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_iobus_uart_tx
// Directed bench for iobus_uart_tx with DIV=10 and a 4-entry FIFO. A small
// receiver task checks every sample of each frame and rebuilds the byte.
// ---------------------------------------------------------------------------
module tb_iobus_uart_tx;
  localparam int          CLK_HZ  = 1_000_000;
  localparam int          BAUD    = 100_000;
  localparam int          DEPTH   = 4;
  localparam logic [31:0] DATA_AD = 32'h1110_0000;
  localparam logic [31:0] STAT_AD = 32'h1110_0004;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;

  iobus_uart_tx_if bus();

  iobus_uart_tx #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH),
    .DATA_AD(DATA_AD), .STAT_AD(STAT_AD)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus),
    .o_tx(tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.iobus_addr = a;
    bus.iobus_out  = d;
    bus.iobus_wr   = 1'b1;
    $display("write addr=0x%08h data=0x%08h", a, d);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    bus.iobus_wr   = 1'b0;
    bus.iobus_addr = 32'h0;
    bus.iobus_out  = 32'h0;
  endtask

  task automatic read_bus(input logic [31:0] a, output logic [31:0] d);
    bus.iobus_addr = a;
    #1;
    d = bus.rd_data;
    bus.iobus_addr = 32'h0;
    $display("read  addr=0x%08h data=0x%08h", a, d);
  endtask

  // Waits (bounded) for a start bit, then checks all 100 samples of the frame.
  task automatic rx_frame(input string tag, input logic [7:0] exp, output int wait_cyc);
    logic [9:0] frame;
    logic [7:0] got;
    bit found;
    int good, hits;
    frame = {1'b1, exp, 1'b0};
    found = 1'b0;
    wait_cyc = -1;
    for (int w = 0; w < 300 && !found; w++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        found = 1'b1;
        wait_cyc = w;
      end
    end
    if (!found) begin
      check({tag, "_start"}, 32'd0, 32'd1);
      return;
    end
    good = 0;
    got  = 8'h00;
    for (int b = 0; b < 10; b++) begin
      hits = 0;
      for (int s = 0; s < 10; s++) begin
        if (!(b == 0 && s == 0)) @(negedge clk);
        if (tx === frame[b]) hits++;
        if (s == 5 && b >= 1 && b <= 8) got[b-1] = tx;
      end
      if (hits == 10) good++;
    end
    $display("rx %s byte=0x%02h wait=%0d", tag, got, wait_cyc);
    check({tag, "_bits"}, 32'(good), 32'd10);
    check({tag, "_byte"}, 32'(got), 32'(exp));
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int w, lows;
    bus.iobus_addr = 32'h0;
    bus.iobus_out  = 32'h0;
    bus.iobus_wr   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    read_bus(STAT_AD, d);
    check("rst_status", d, 32'h0000_0002);

    // 1: single byte 0x55, latency and BUSY
    bus_write(DATA_AD, 32'h55);
    bus_idle();
    @(negedge clk);
    check("t1_tx_before_start", 32'(tx), 32'd1);
    read_bus(STAT_AD, d);
    check("t1_busy", d, 32'h0000_0003);
    rx_frame("t1", 8'h55, w);
    check("t1_latency", 32'(w), 32'd0);
    read_bus(STAT_AD, d);
    check("t1_idle_after", d, 32'h0000_0002);

    // 2: back-to-back bytes, no idle gap
    bus_write(DATA_AD, 32'h01);
    bus_write(DATA_AD, 32'h02);
    bus_idle();
    rx_frame("t2a", 8'h01, w);
    check("t2a_wait", 32'(w), 32'd0);
    rx_frame("t2b", 8'h02, w);
    check("t2b_gap", 32'(w), 32'd0);

    // 3: six consecutive writes, overflow on the sixth
    fork
      begin
        bus_write(DATA_AD, 32'h11);
        bus_write(DATA_AD, 32'h22);
        bus_write(DATA_AD, 32'h33);
        bus_write(DATA_AD, 32'h44);
        bus_write(DATA_AD, 32'h5A);
        bus_write(DATA_AD, 32'h66);
        bus_idle();
        read_bus(STAT_AD, d);
        check("t3_full_ovf", d, 32'h0000_040D);
      end
      begin
        int ww;
        rx_frame("t3_0", 8'h11, ww);
        rx_frame("t3_1", 8'h22, ww);
        rx_frame("t3_2", 8'h33, ww);
        rx_frame("t3_3", 8'h44, ww);
        rx_frame("t3_4", 8'h5A, ww);
      end
    join
    count_low(40, lows);
    check("t3_no_sixth", 32'(lows), 32'd0);
    read_bus(STAT_AD, d);
    check("t3_ovf_sticky", d, 32'h0000_000A);
    bus_write(STAT_AD, 32'h2);
    bus_idle();
    read_bus(STAT_AD, d);
    check("t3_ovf_keep", d, 32'h0000_000A);
    bus_write(STAT_AD, 32'h1);
    bus_idle();
    read_bus(STAT_AD, d);
    check("t3_ovf_clr", d, 32'h0000_0002);

    // 4: reset during data bit 3 of 0xA5 with two bytes queued
    bus_write(DATA_AD, 32'hA5);
    bus_write(DATA_AD, 32'h3C);
    bus_write(DATA_AD, 32'hC3);
    bus_idle();
    check("t4_start", 32'(tx), 32'd0);
    repeat (45) @(negedge clk);
    check("t4_bit3", 32'(tx), 32'd0);
    read_bus(STAT_AD, d);
    check("t4_queued", d, 32'h0000_0201);
    rst = 1'b1;
    @(negedge clk);
    check("t4_tx_after_rst", 32'(tx), 32'd1);
    rst = 1'b0;
    read_bus(STAT_AD, d);
    check("t4_status", d, 32'h0000_0002);
    count_low(120, lows);
    check("t4_stays_high", 32'(lows), 32'd0);

    // 5: status decode
    read_bus(STAT_AD, d);
    check("t5_stat", d, 32'h0000_0002);
    read_bus(DATA_AD, d);
    check("t5_data_ad_rd", d, 32'h0);
    read_bus(32'h1110_0008, d);
    check("t5_other_rd", d, 32'h0);

    // 6: foreign addresses ignored; upper data bits ignored
    bus_write(32'h1110_0008, 32'h55);
    bus_write(32'h1108_0000, 32'h55);
    bus_write(32'h9110_0000, 32'h55);
    bus_idle();
    read_bus(STAT_AD, d);
    check("t6_status", d, 32'h0000_0002);
    count_low(30, lows);
    check("t6_tx_high", 32'(lows), 32'd0);
    bus_write(DATA_AD, 32'hDEAD_BE42);
    bus_idle();
    rx_frame("t6_lowbyte", 8'h42, w);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
